// File: rtl/pwm_bridge_driver.sv
// Multi-channel complementary PWM generator with shadowed configuration,
// edge/center-aligned counting, per-channel dead-time insertion and brake.
module pwm_bridge_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 3,
    parameter int DT_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pwm_en,
    input  logic                           center_mode,
    input  logic [DATA_WIDTH-1:0]          pwm_period,
    input  logic [CHANNELS*DATA_WIDTH-1:0] duty,
    input  logic [DT_WIDTH-1:0]            deadtime,
    input  logic                           load,
    input  logic                           brake,
    output logic [CHANNELS-1:0]            motorpo,
    output logic [CHANNELS-1:0]            motorne,
    output logic                           period_start,
    output logic                           load_ack
);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
    localparam logic [DT_WIDTH:0]     LEN_ONE = (DT_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0]          sh_period;
    logic [CHANNELS*DATA_WIDTH-1:0] sh_duty;
    logic [DT_WIDTH-1:0]            sh_dt;
    logic                           sh_center;
    logic                           pending;

    logic [DATA_WIDTH-1:0]          act_period;
    logic [CHANNELS*DATA_WIDTH-1:0] act_duty;
    logic [DT_WIDTH-1:0]            act_dt;
    logic                           act_center;

    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] cnt_next;
    logic                  dir;
    logic                  dir_next;
    logic                  run;
    logic                  wrap;
    logic                  transfer;
    logic                  enabled;

    logic [CHANNELS-1:0]             raw;
    logic [CHANNELS-1:0]             settled;
    logic [CHANNELS-1:0]             last_raw;
    logic [CHANNELS-1:0]             tracking;
    logic [CHANNELS-1:0][DT_WIDTH:0] run_len;
    logic [CHANNELS-1:0][DT_WIDTH:0] run_len_next;
    logic [DT_WIDTH:0]               dt_ext;

    assign run          = pwm_en && (act_period != '0);
    assign enabled      = run && !brake;
    assign transfer     = pending && (wrap || !pwm_en || (act_period == '0));
    assign period_start = run && (cnt == '0);
    assign dt_ext       = {1'b0, act_dt};

    // Next count and direction; wrap flags the edge on which cnt returns to 0.
    always_comb begin
        cnt_next = '0;
        dir_next = DIR_UP;
        wrap     = 1'b0;
        if (run) begin
            if (!act_center) begin
                if (cnt >= act_period - ONE) begin
                    wrap = 1'b1;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end else if (dir == DIR_UP) begin
                if (cnt >= act_period) begin
                    if (act_period == ONE) begin
                        wrap = 1'b1;
                    end else begin
                        cnt_next = act_period - ONE;
                        dir_next = DIR_DOWN;
                    end
                end else begin
                    cnt_next = cnt + ONE;
                end
            end else begin
                if (cnt <= ONE) begin
                    wrap = 1'b1;
                end else begin
                    cnt_next = cnt - ONE;
                    dir_next = DIR_DOWN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else begin
            cnt <= cnt_next;
            dir <= dir_next;
        end
    end

    // A load coinciding with a transfer bypasses the shadow so the newest values win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_period  <= '0;
            sh_duty    <= '0;
            sh_dt      <= '0;
            sh_center  <= 1'b0;
            act_period <= '0;
            act_duty   <= '0;
            act_dt     <= '0;
            act_center <= 1'b0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            if (load) begin
                sh_period <= pwm_period;
                sh_duty   <= duty;
                sh_dt     <= deadtime;
                sh_center <= center_mode;
            end
            if (transfer) begin
                act_period <= load ? pwm_period  : sh_period;
                act_duty   <= load ? duty        : sh_duty;
                act_dt     <= load ? deadtime    : sh_dt;
                act_center <= load ? center_mode : sh_center;
            end
            pending  <= (pending | load) & ~transfer;
            load_ack <= transfer;
        end
    end

    // An output may rise only once raw has held its level for deadtime+1 samples;
    // run_len saturates just above the dead time so it never overflows.
    always_comb begin
        raw          = '0;
        settled      = '0;
        run_len_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (act_duty[i*DATA_WIDTH +: DATA_WIDTH] >= act_period) ||
                     (cnt < act_duty[i*DATA_WIDTH +: DATA_WIDTH]);
            if (tracking[i] && (raw[i] == last_raw[i])) begin
                run_len_next[i] = (run_len[i] > dt_ext) ? run_len[i] : run_len[i] + LEN_ONE;
            end else begin
                run_len_next[i] = LEN_ONE;
            end
            settled[i] = run_len_next[i] > dt_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            motorpo  <= '0;
            motorne  <= '0;
            tracking <= '0;
            last_raw <= '0;
            run_len  <= '0;
        end else if (!enabled) begin
            motorpo  <= '0;
            motorne  <= '0;
            tracking <= '0;
            run_len  <= '0;
        end else begin
            motorpo  <= raw & settled;
            motorne  <= ~raw & settled;
            tracking <= '1;
            last_raw <= raw;
            run_len  <= run_len_next;
        end
    end

endmodule

// File: tb/tb_pwm_bridge_driver.sv
// Directed bench for pwm_bridge_driver: table of steady-state configurations plus
// hand-written sequences for shadow loading, brake and mid-cycle reset.
module tb_pwm_bridge_driver;

    logic        clk;
    logic        reset;
    logic        pwm_en;
    logic        center_mode;
    logic [15:0] pwm_period;
    logic [47:0] duty;
    logic [7:0]  deadtime;
    logic        load;
    logic        brake;
    logic [2:0]  motorpo;
    logic [2:0]  motorne;
    logic        period_start;
    logic        load_ack;

    int checks;
    int errors;
    int po_hi [3];
    int ne_hi [3];
    int overlap;
    int cyc_len;

    typedef struct {
        int period; int d0; int d1; int d2; int dt; int center;
        int po0; int po1; int po2; int ne0; int ne1; int ne2; int len;
    } vec_t;

    vec_t vecs [6];

    pwm_bridge_driver #(.DATA_WIDTH(16), .CHANNELS(3), .DT_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .pwm_en       (pwm_en),
        .center_mode  (center_mode),
        .pwm_period   (pwm_period),
        .duty         (duty),
        .deadtime     (deadtime),
        .load         (load),
        .brake        (brake),
        .motorpo      (motorpo),
        .motorne      (motorne),
        .period_start (period_start),
        .load_ack     (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts output activity over one full PWM cycle, start pulse to start pulse.
    task automatic measure();
        bit ok;
        int n;
        wait_start(ok);
        if (!ok) begin
            check_output("period_start_timeout", 0, 1);
            return;
        end
        for (int c = 0; c < 3; c++) begin
            po_hi[c] = 0;
            ne_hi[c] = 0;
        end
        overlap = 0;
        n = 0;
        do begin
            for (int c = 0; c < 3; c++) begin
                po_hi[c] += int'(motorpo[c]);
                ne_hi[c] += int'(motorne[c]);
            end
            if ((motorpo & motorne) != 3'b000) overlap++;
            n++;
            @(negedge clk);
        end while (!period_start && n < 200);
        cyc_len = n;
    endtask

    // Stops the counter, loads a configuration while idle and starts it again.
    task automatic apply_stimulus(input int period, input int d0, input int d1, input int d2,
                                  input int dt, input int center);
        pwm_en = 1'b0;
        step();
        step();
        pwm_period  = 16'(period);
        duty        = {16'(d2), 16'(d1), 16'(d0)};
        deadtime    = 8'(dt);
        center_mode = (center != 0);
        load        = 1'b1;
        step();
        load = 1'b0;
        step();
        check_output("idle_load_ack", int'(load_ack), 1);
        pwm_en = 1'b1;
    endtask

    task automatic load_sequence();
        bit ok;
        int n;
        int acks;
        apply_stimulus(10, 2, 5, 8, 0, 0);
        measure();
        wait_start(ok);
        if (!ok) begin
            check_output("load_seq_timeout", 0, 1);
            return;
        end
        step(); step(); step();
        pwm_period = 16'd30;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        pwm_period = 16'd20;
        load = 1'b1;
        step();
        load = 1'b0;
        n = 6;
        acks = 0;
        do begin
            step();
            n++;
            acks += int'(load_ack);
        end while (!period_start && n < 100);
        check_output("old_period_len", n, 10);
        check_output("ack_at_wrap", int'(load_ack), 1);
        n = 0;
        do begin
            step();
            n++;
            acks += int'(load_ack);
        end while (!period_start && n < 100);
        check_output("new_period_len", n, 20);
        check_output("single_ack", acks, 1);
    endtask

    task automatic brake_sequence();
        bit ok;
        int lows;
        int seen;
        apply_stimulus(10, 5, 5, 5, 3, 0);
        measure();
        check_output("brake_cfg_po0", po_hi[0], 2);
        check_output("brake_cfg_ne0", ne_hi[0], 2);
        wait_start(ok);
        if (!ok) begin
            check_output("brake_seq_timeout", 0, 1);
            return;
        end
        step(); step(); step(); step();
        brake = 1'b1;
        step();
        check_output("brake_po_off", int'(motorpo), 0);
        check_output("brake_ne_off", int'(motorne), 0);
        lows = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if ((motorpo | motorne) == 3'b000) lows++;
        end
        check_output("brake_held_low", lows, 3);
        brake = 1'b0;
        lows = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if ((motorpo | motorne) == 3'b000) lows++;
            if (k == 1) check_output("brake_counter_runs", int'(period_start), 1);
        end
        check_output("release_deadtime_low", lows, 3);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if ((motorpo | motorne) != 3'b000) seen = 1;
        end
        check_output("release_resumes", seen, 1);
        pwm_en = 1'b0;
        step();
        check_output("disable_po", int'(motorpo), 0);
        check_output("disable_ne", int'(motorne), 0);
        check_output("disable_ps", int'(period_start), 0);
    endtask

    task automatic reset_sequence();
        bit ok;
        int bad_out;
        int bad_ps;
        apply_stimulus(10, 2, 5, 8, 0, 0);
        measure();
        wait_start(ok);
        if (!ok) begin
            check_output("reset_seq_timeout", 0, 1);
            return;
        end
        step();
        check_output("pre_reset_po", int'(motorpo), 7);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_reset_po", int'(motorpo), 0);
        check_output("async_reset_ne", int'(motorne), 0);
        step();
        reset = 1'b1;
        bad_out = 0;
        bad_ps  = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if ((motorpo | motorne) != 3'b000) bad_out++;
            if (period_start) bad_ps++;
        end
        check_output("post_reset_outputs", bad_out, 0);
        check_output("post_reset_period_start", bad_ps, 0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        pwm_en      = 1'b0;
        center_mode = 1'b0;
        pwm_period  = '0;
        duty        = '0;
        deadtime    = '0;
        load        = 1'b0;
        brake       = 1'b0;

        // period, duty0..2, dt, center, expected po highs, ne highs, cycle length
        vecs[0] = '{10,  2,  5,  8, 0, 0,   2,  5,  8,   8,  5,  2,  10};
        vecs[1] = '{10,  5,  0, 12, 2, 1,   7,  0, 20,   9, 20,  0,  20};
        vecs[2] = '{10,  0, 12, 10, 3, 0,   0, 10, 10,  10,  0,  0,  10};
        vecs[3] = '{ 8,  3,  1,  7, 1, 0,   2,  0,  6,   4,  6,  0,   8};
        vecs[4] = '{ 6,  2,  4,  6, 1, 1,   2,  6, 12,   8,  4,  0,  12};
        vecs[5] = '{ 5,  1,  3,  4, 0, 1,   1,  5,  7,   9,  5,  3,  10};

        step();
        step();
        check_output("reset_po", int'(motorpo), 0);
        check_output("reset_ne", int'(motorne), 0);
        check_output("reset_period_start", int'(period_start), 0);
        check_output("reset_load_ack", int'(load_ack), 0);
        reset = 1'b1;
        step();
        step();
        check_output("idle_po", int'(motorpo), 0);
        check_output("idle_period_start", int'(period_start), 0);

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].period, vecs[v].d0, vecs[v].d1, vecs[v].d2,
                           vecs[v].dt, vecs[v].center);
            measure();
            measure();
            check_output($sformatf("v%0d_len", v), cyc_len, vecs[v].len);
            check_output($sformatf("v%0d_po0", v), po_hi[0], vecs[v].po0);
            check_output($sformatf("v%0d_po1", v), po_hi[1], vecs[v].po1);
            check_output($sformatf("v%0d_po2", v), po_hi[2], vecs[v].po2);
            check_output($sformatf("v%0d_ne0", v), ne_hi[0], vecs[v].ne0);
            check_output($sformatf("v%0d_ne1", v), ne_hi[1], vecs[v].ne1);
            check_output($sformatf("v%0d_ne2", v), ne_hi[2], vecs[v].ne2);
            check_output($sformatf("v%0d_overlap", v), overlap, 0);
        end

        load_sequence();
        brake_sequence();
        reset_sequence();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
